gb_if_wr_feed: RTL and testbench

Upstream feeder for the GB SRAM write controller. On each write-configuration request it forwards the target SRAM ID to the off-chip host interface. It then grants the write controller and packs narrow host beats into SRAM-width words. Those words are streamed into the write controller's IFSRAM_Wr_val / SRAMIF_Wr_rdy handshake until one full SRAM (SRAM_DEPTH words) has been delivered.

---
 rtl/gb_if_wr_feed_pkg.sv | 19 +
 rtl/gb_if_pack_fifo.sv | 96 +++++++++
 rtl/gb_if_wr_feed.sv | 121 ++++++++++++
 tb/tb_gb_if_wr_feed.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_if_wr_feed_pkg.sv
// gb_if_wr_feed_pkg
//   Shared definitions for the GB SRAM write-feed path.
//   - gb_state_e : feeder FSM encoding (IDLE/REQ/GRANT/STREAM = 00/01/10/11)
//   - GB_* constants : default host beat, SRAM word and SRAM ID widths
package gb_if_wr_feed_pkg;

  localparam int GB_SRAM_ADDRWIDTH = 9;
  localparam int GB_IF_WIDTH       = 32;
  localparam int GB_SRAM_WIDTH     = 128;
  localparam int GB_ID_WIDTH       = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    GRANT  = 2'b10,
    STREAM = 2'b11
  } gb_state_e;

endpackage

// File: rtl/gb_if_pack_fifo.sv
// gb_if_pack_fifo
//   Packs RATIO narrow host beats into one SRAM-width word (first beat in the
//   LSBs) and queues completed words in a 2-entry FIFO whose head is a
//   register, so the presented word never glitches while it waits.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear of packer, beat counter and FIFO
//   beat_val    : a host beat is accepted this cycle
//   beat_data   : the accepted host beat
//   pop         : consumer takes the FIFO head this cycle (only when fifo_cnt!=0)
//   head_data   : FIFO head word
//   fifo_cnt    : number of queued words (0..2)
//   push        : a completed word enters the FIFO this cycle
module gb_if_pack_fifo
  import gb_if_wr_feed_pkg::*;
#(
  parameter int IF_WIDTH   = GB_IF_WIDTH,
  parameter int SRAM_WIDTH = GB_SRAM_WIDTH,
  parameter int RATIO      = SRAM_WIDTH / IF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  beat_val,
  input  logic [IF_WIDTH-1:0]   beat_data,
  input  logic                  pop,
  output logic [SRAM_WIDTH-1:0] head_data,
  output logic [1:0]            fifo_cnt,
  output logic                  push
);

  localparam int BW = $clog2(RATIO);

  logic [BW-1:0]         beat_cnt;
  logic [SRAM_WIDTH-1:0] pack_reg;
  logic [SRAM_WIDTH-1:0] word_next;
  logic [SRAM_WIDTH-1:0] entry1;

  // The word as it would look with the current beat merged in; on the last
  // beat this is what gets pushed, so the final beat bypasses pack_reg.
  always_comb begin
    word_next = pack_reg;
    word_next[beat_cnt*IF_WIDTH +: IF_WIDTH] = beat_data;
  end

  assign push = beat_val && (beat_cnt == BW'(RATIO - 1));

  // Beat counter wraps naturally because RATIO is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      pack_reg <= '0;
    end else if (flush) begin
      beat_cnt <= '0;
      pack_reg <= '0;
    end else if (beat_val) begin
      beat_cnt <= beat_cnt + 1'b1;
      pack_reg <= word_next;
    end
  end

  // Shift-style FIFO: head_data is always entry 0, entry1 moves up on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt  <= 2'd0;
      head_data <= '0;
      entry1    <= '0;
    end else if (flush) begin
      fifo_cnt  <= 2'd0;
      head_data <= '0;
      entry1    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) head_data <= word_next;
          else                  entry1    <= word_next;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          head_data <= entry1;
          fifo_cnt  <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            head_data <= word_next;
          end else begin
            head_data <= entry1;
            entry1    <= word_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gb_if_wr_feed.sv
// gb_if_wr_feed
//   Feeder for the GB SRAM write controller. A fill request forwards the SRAM
//   ID to the host, grants the write controller for one cycle, then streams
//   SRAM_DEPTH packed words into the controller's valid/ready handshake.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   SRAM_config_start           : synchronous abort back to IDLE
//   SRAMIF_Conf_val/_Wr_ID      : fill request and target SRAM ID
//   IFSRAM_Conf_rdy             : one-cycle grant to the write controller
//   SRAMIF_Wr_rdy               : controller accepts a word
//   IFSRAM_Wr_val/_Wr_data      : packed word to the controller
//   IF_Req_val/_ID, IF_Req_rdy  : fill request to the host
//   IF_Dat_val/IF_Dat, IF_Dat_rdy : host beat handshake
module gb_if_wr_feed
  import gb_if_wr_feed_pkg::*;
#(
  parameter int SRAM_ADDRWIDTH = GB_SRAM_ADDRWIDTH,
  parameter int SRAM_DEPTH     = 2 ** SRAM_ADDRWIDTH,
  parameter int IF_WIDTH       = GB_IF_WIDTH,
  parameter int SRAM_WIDTH     = GB_SRAM_WIDTH,
  parameter int RATIO          = SRAM_WIDTH / IF_WIDTH,
  parameter int ID_WIDTH       = GB_ID_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SRAM_config_start,
  input  logic                  SRAMIF_Conf_val,
  input  logic [ID_WIDTH-1:0]   SRAMIF_Wr_ID,
  output logic                  IFSRAM_Conf_rdy,
  input  logic                  SRAMIF_Wr_rdy,
  output logic                  IFSRAM_Wr_val,
  output logic [SRAM_WIDTH-1:0] IFSRAM_Wr_data,
  output logic                  IF_Req_val,
  output logic [ID_WIDTH-1:0]   IF_Req_ID,
  input  logic                  IF_Req_rdy,
  input  logic                  IF_Dat_val,
  input  logic [IF_WIDTH-1:0]   IF_Dat,
  output logic                  IF_Dat_rdy
);

  localparam int CW = SRAM_ADDRWIDTH + 1;

  gb_state_e     state, state_next;
  logic [CW-1:0] in_words;
  logic [CW-1:0] out_words;
  logic [1:0]    fifo_cnt;
  logic          push;
  logic          pop;
  logic          beat_acc;
  logic          last_pop;
  logic          flush;

  assign IF_Req_val      = (state == REQ);
  assign IFSRAM_Conf_rdy = (state == GRANT);
  assign IFSRAM_Wr_val   = (state == STREAM) && (fifo_cnt != 2'd0);
  assign IF_Dat_rdy      = (state == STREAM) && (in_words < CW'(SRAM_DEPTH))
                           && (fifo_cnt < 2'd2);

  assign beat_acc = IF_Dat_val && IF_Dat_rdy;
  assign pop      = IFSRAM_Wr_val && SRAMIF_Wr_rdy;
  assign last_pop = pop && (out_words == CW'(SRAM_DEPTH - 1));
  // Completing a fill reuses the abort clear path; the FIFO is already empty
  // then because no more words can have been pushed.
  assign flush    = SRAM_config_start || last_pop;

  gb_if_pack_fifo #(
    .IF_WIDTH  (IF_WIDTH),
    .SRAM_WIDTH(SRAM_WIDTH),
    .RATIO     (RATIO)
  ) u_pack (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .beat_val (beat_acc),
    .beat_data(IF_Dat),
    .pop      (pop),
    .head_data(IFSRAM_Wr_data),
    .fifo_cnt (fifo_cnt),
    .push     (push)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Abort overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (SRAMIF_Conf_val) state_next = REQ;
      REQ:     if (IF_Req_rdy)      state_next = GRANT;
      GRANT:                        state_next = STREAM;
      STREAM:  if (last_pop)        state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
    if (SRAM_config_start) state_next = IDLE;
  end

  // The requested ID is captured only when a request is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      IF_Req_ID <= '0;
    else if (state == IDLE && SRAMIF_Conf_val && !SRAM_config_start)
      IF_Req_ID <= SRAMIF_Wr_ID;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_words  <= '0;
      out_words <= '0;
    end else if (flush) begin
      in_words  <= '0;
      out_words <= '0;
    end else begin
      if (push) in_words  <= in_words + 1'b1;
      if (pop)  out_words <= out_words + 1'b1;
    end
  end

endmodule

// File: tb/tb_gb_if_wr_feed.sv
// tb_gb_if_wr_feed
//   Directed bench for gb_if_wr_feed: reset, request/grant, first-word
//   packing, back-pressure, abort/restart and a full 512-word fill.
module tb_gb_if_wr_feed;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         SRAM_config_start = 1'b0;
  logic         SRAMIF_Conf_val = 1'b0;
  logic [5:0]   SRAMIF_Wr_ID = '0;
  logic         IFSRAM_Conf_rdy;
  logic         SRAMIF_Wr_rdy = 1'b0;
  logic         IFSRAM_Wr_val;
  logic [127:0] IFSRAM_Wr_data;
  logic         IF_Req_val;
  logic [5:0]   IF_Req_ID;
  logic         IF_Req_rdy = 1'b0;
  logic         IF_Dat_val = 1'b0;
  logic [31:0]  IF_Dat = '0;
  logic         IF_Dat_rdy;

  int           vectors = 0;
  int           miscompares = 0;
  logic [31:0]  next_beat = '0;

  always #5 clk = ~clk;

  gb_if_wr_feed dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .SRAM_config_start(SRAM_config_start),
    .SRAMIF_Conf_val  (SRAMIF_Conf_val),
    .SRAMIF_Wr_ID     (SRAMIF_Wr_ID),
    .IFSRAM_Conf_rdy  (IFSRAM_Conf_rdy),
    .SRAMIF_Wr_rdy    (SRAMIF_Wr_rdy),
    .IFSRAM_Wr_val    (IFSRAM_Wr_val),
    .IFSRAM_Wr_data   (IFSRAM_Wr_data),
    .IF_Req_val       (IF_Req_val),
    .IF_Req_ID        (IF_Req_ID),
    .IF_Req_rdy       (IF_Req_rdy),
    .IF_Dat_val       (IF_Dat_val),
    .IF_Dat           (IF_Dat),
    .IF_Dat_rdy       (IF_Dat_rdy)
  );

  // Word built from four consecutive beats starting at b0, first beat in LSBs.
  function automatic logic [127:0] mk_word(input logic [31:0] b0);
    return {b0 + 32'd3, b0 + 32'd2, b0 + 32'd1, b0};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #2;
    vectors++;
    if ({IF_Req_val, IFSRAM_Conf_rdy, IFSRAM_Wr_val, IF_Dat_rdy} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000",
               {IF_Req_val, IFSRAM_Conf_rdy, IFSRAM_Wr_val, IF_Dat_rdy});
    end
    vectors++;
    if (IFSRAM_Wr_data !== 128'd0 || IF_Req_ID !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: data=%h id=%0d expected 0/0", IFSRAM_Wr_data, IF_Req_ID);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    vectors++;
    if ({IF_Req_val, IFSRAM_Conf_rdy, IFSRAM_Wr_val, IF_Dat_rdy} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got %b expected 0000",
               {IF_Req_val, IFSRAM_Conf_rdy, IFSRAM_Wr_val, IF_Dat_rdy});
    end
  endtask

  task automatic test_request;
    SRAMIF_Conf_val = 1'b1;
    SRAMIF_Wr_ID    = 6'd13;
    IF_Req_rdy      = 1'b1;
    step();
    SRAMIF_Conf_val = 1'b0;
    SRAMIF_Wr_ID    = 6'd0;
    vectors++;
    if (IF_Req_val !== 1'b1 || IF_Req_ID !== 6'd13 || IFSRAM_Conf_rdy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL req_phase: val=%b id=%0d conf_rdy=%b expected 1/13/0",
               IF_Req_val, IF_Req_ID, IFSRAM_Conf_rdy);
    end
    step();
    vectors++;
    if (IF_Req_val !== 1'b0 || IFSRAM_Conf_rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL grant_phase: req_val=%b conf_rdy=%b expected 0/1",
               IF_Req_val, IFSRAM_Conf_rdy);
    end
    step();
    IF_Req_rdy = 1'b0;
    vectors++;
    if (IFSRAM_Conf_rdy !== 1'b0 || IF_Dat_rdy !== 1'b1 || IFSRAM_Wr_val !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stream_entry: conf_rdy=%b dat_rdy=%b wr_val=%b expected 0/1/0",
               IFSRAM_Conf_rdy, IF_Dat_rdy, IFSRAM_Wr_val);
    end
  endtask

  task automatic test_first_word;
    int not_rdy = 0;
    SRAMIF_Wr_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IF_Dat_val = 1'b1;
      IF_Dat     = 32'(i);
      if (IF_Dat_rdy !== 1'b1) not_rdy++;
      step();
    end
    IF_Dat_val = 1'b0;
    next_beat  = 32'd4;
    vectors++;
    if (not_rdy != 0) begin
      miscompares++;
      $display("[TB] FAIL first_word_rdy: %0d beats refused expected 0", not_rdy);
    end
    vectors++;
    if (IFSRAM_Wr_val !== 1'b1 || IFSRAM_Wr_data !== mk_word(32'd0)) begin
      miscompares++;
      $display("[TB] FAIL first_word: val=%b data=%h expected 1/%h",
               IFSRAM_Wr_val, IFSRAM_Wr_data, mk_word(32'd0));
    end
    step();
    vectors++;
    if (IFSRAM_Wr_val !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL first_word_pop: wr_val=%b expected 0", IFSRAM_Wr_val);
    end
  endtask

  task automatic test_back_pressure;
    int accepted = 0;
    int held_bad = 0;
    int pops = 0;
    logic acc;
    SRAMIF_Wr_rdy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      IF_Dat_val = 1'b1;
      IF_Dat     = next_beat;
      acc        = IF_Dat_rdy;
      if (IFSRAM_Wr_val === 1'b1 && IFSRAM_Wr_data !== mk_word(32'd4)) held_bad++;
      step();
      if (acc) begin
        accepted++;
        next_beat++;
      end
    end
    vectors++;
    if (accepted != 8) begin
      miscompares++;
      $display("[TB] FAIL stall_beats: got %0d accepted expected 8", accepted);
    end
    vectors++;
    if (IF_Dat_rdy !== 1'b0 || IFSRAM_Wr_val !== 1'b1 || held_bad != 0) begin
      miscompares++;
      $display("[TB] FAIL stall_hold: dat_rdy=%b wr_val=%b unstable=%0d expected 0/1/0",
               IF_Dat_rdy, IFSRAM_Wr_val, held_bad);
    end
    IF_Dat_val    = 1'b0;
    SRAMIF_Wr_rdy = 1'b1;
    for (int c = 0; c < 10 && pops < 2; c++) begin
      if (IFSRAM_Wr_val === 1'b1) begin
        vectors++;
        if (IFSRAM_Wr_data !== mk_word(32'(4 + 4 * pops))) begin
          miscompares++;
          $display("[TB] FAIL drain_word%0d: got %h expected %h",
                   pops, IFSRAM_Wr_data, mk_word(32'(4 + 4 * pops)));
        end
        pops++;
      end
      step();
    end
    vectors++;
    if (pops != 2 || IFSRAM_Wr_val !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drain_count: pops=%0d wr_val=%b expected 2/0", pops, IFSRAM_Wr_val);
    end
  endtask

  task automatic test_abort;
    int fed = 0;
    logic acc;
    SRAMIF_Wr_rdy = 1'b1;
    for (int c = 0; c < 40 && fed < 10; c++) begin
      IF_Dat_val = 1'b1;
      IF_Dat     = next_beat;
      acc        = IF_Dat_rdy;
      step();
      if (acc) begin
        fed++;
        next_beat++;
      end
    end
    IF_Dat_val = 1'b0;
    vectors++;
    if (fed != 10) begin
      miscompares++;
      $display("[TB] FAIL abort_feed: got %0d beats expected 10", fed);
    end
    SRAM_config_start = 1'b1;
    step();
    SRAM_config_start = 1'b0;
    vectors++;
    if ({IFSRAM_Wr_val, IF_Dat_rdy, IF_Req_val, IFSRAM_Conf_rdy} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL abort_idle: got %b expected 0000",
               {IFSRAM_Wr_val, IF_Dat_rdy, IF_Req_val, IFSRAM_Conf_rdy});
    end
    vectors++;
    if (IF_Req_ID !== 6'd13) begin
      miscompares++;
      $display("[TB] FAIL abort_id_hold: got %0d expected 13", IF_Req_ID);
    end
  endtask

  task automatic test_conf_stall;
    int bad = 0;
    SRAMIF_Conf_val = 1'b1;
    SRAMIF_Wr_ID    = 6'd21;
    IF_Req_rdy      = 1'b0;
    step();
    for (int c = 0; c < 10; c++) begin
      if (IF_Req_val !== 1'b1 || IFSRAM_Conf_rdy !== 1'b0 || IF_Req_ID !== 6'd21) bad++;
      step();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL req_stall: %0d bad cycles expected 0", bad);
    end
    IF_Req_rdy = 1'b1;
    step();
    IF_Req_rdy = 1'b0;
    vectors++;
    if (IFSRAM_Conf_rdy !== 1'b1 || IF_Req_val !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_grant: conf_rdy=%b req_val=%b expected 1/0",
               IFSRAM_Conf_rdy, IF_Req_val);
    end
    step();
    SRAMIF_Conf_val = 1'b0;
    vectors++;
    if (IFSRAM_Conf_rdy !== 1'b0 || IF_Dat_rdy !== 1'b1 || IF_Req_val !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_stream: conf_rdy=%b dat_rdy=%b req_val=%b expected 0/1/0",
               IFSRAM_Conf_rdy, IF_Dat_rdy, IF_Req_val);
    end
  endtask

  task automatic test_full_fill;
    int pops = 0;
    int idle_bad = 0;
    logic acc, pp;
    next_beat = 32'd0;
    for (int cyc = 0; cyc < 20000 && pops < 512; cyc++) begin
      IF_Dat_val    = ($urandom_range(0, 3) != 0);
      IF_Dat        = next_beat;
      SRAMIF_Wr_rdy = ($urandom_range(0, 2) != 0);
      acc = IF_Dat_val && IF_Dat_rdy;
      pp  = IFSRAM_Wr_val && SRAMIF_Wr_rdy;
      if (pp) begin
        vectors++;
        if (IFSRAM_Wr_data !== mk_word(32'(4 * pops))) begin
          miscompares++;
          $display("[TB] FAIL fill_word%0d: got %h expected %h",
                   pops, IFSRAM_Wr_data, mk_word(32'(4 * pops)));
        end
      end
      step();
      if (acc) next_beat++;
      if (pp)  pops++;
    end
    vectors++;
    if (pops != 512 || next_beat != 32'd2048) begin
      miscompares++;
      $display("[TB] FAIL fill_count: pops=%0d beats=%0d expected 512/2048", pops, next_beat);
    end
    vectors++;
    if ({IFSRAM_Wr_val, IF_Dat_rdy, IF_Req_val, IFSRAM_Conf_rdy} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL fill_idle: got %b expected 0000",
               {IFSRAM_Wr_val, IF_Dat_rdy, IF_Req_val, IFSRAM_Conf_rdy});
    end
    IF_Dat_val    = 1'b1;
    SRAMIF_Wr_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (IF_Dat_rdy !== 1'b0 || IFSRAM_Wr_val !== 1'b0) idle_bad++;
      step();
    end
    IF_Dat_val = 1'b0;
    vectors++;
    if (idle_bad != 0) begin
      miscompares++;
      $display("[TB] FAIL idle_no_accept: %0d bad cycles expected 0", idle_bad);
    end
    SRAMIF_Conf_val = 1'b1;
    SRAMIF_Wr_ID    = 6'd7;
    step();
    SRAMIF_Conf_val = 1'b0;
    vectors++;
    if (IF_Req_val !== 1'b1 || IF_Req_ID !== 6'd7) begin
      miscompares++;
      $display("[TB] FAIL refill_req: val=%b id=%0d expected 1/7", IF_Req_val, IF_Req_ID);
    end
  endtask

  initial begin
    test_reset();
    test_request();
    test_first_word();
    test_back_pressure();
    test_abort();
    test_conf_stall();
    test_full_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
